// File: rtl/data_bus_responder.sv
// Word-addressed CPU bus responder: backing store plus one memory-mapped output register.
// Response after WAIT_STATES+1 cycles as a one-cycle ready pulse; requests are only taken in IDLE.
module data_bus_responder #(
  parameter int                           DATA_BUS_WIDTH    = 24,
  parameter int                           ADDRESS_BUS_WIDTH = 12,
  parameter int                           MEM_DEPTH         = 256,
  parameter int                           WAIT_STATES       = 2,
  parameter logic [ADDRESS_BUS_WIDTH-1:0] IO_ADDRESS        = 12'hFFF
) (
  input  logic                         mainClock,
  input  logic                         reset,
  input  logic                         cs,
  input  logic                         read_not_write,
  input  logic [ADDRESS_BUS_WIDTH-1:0] address,
  input  logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic                         ready,
  output logic                         err,
  output logic                         busy,
  output logic [DATA_BUS_WIDTH-1:0]    io_out
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2^ADDRESS_BUS_WIDTH still compares correctly.
  localparam logic [ADDRESS_BUS_WIDTH:0] LP_DEPTH    = (ADDRESS_BUS_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]                 LP_CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [3:0]                     r_cnt;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_addr;
  logic                           r_rnw;
  logic [DATA_BUS_WIDTH-1:0]      r_wdata;
  logic [DATA_BUS_WIDTH-1:0]      r_rdata;
  logic [DATA_BUS_WIDTH-1:0]      r_io;
  logic [DATA_BUS_WIDTH-1:0]      r_mem [MEM_DEPTH];

  logic                           w_accept;
  logic                           w_resp;
  logic                           w_is_io;
  logic                           w_is_mem;
  logic [IDX_W-1:0]               w_idx;
  logic [DATA_BUS_WIDTH-1:0]      w_rd_val;

  assign w_accept = (r_state == IDLE) && cs;
  assign w_resp   = (r_state == RESP);
  // IO register wins over a store word at the same address.
  assign w_is_io  = (r_addr == IO_ADDRESS);
  assign w_is_mem = !w_is_io && ({1'b0, r_addr} < LP_DEPTH);
  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_rd_val = w_is_io ? r_io : (w_is_mem ? r_mem[w_idx] : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (cs) w_state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd0) w_state_nxt = RESP;
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mainClock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_rnw   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_io    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= LP_CNT_INIT;
        r_addr  <= address;
        r_rnw   <= read_not_write;
        r_wdata <= write_data;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_resp && r_rnw) r_rdata <= w_rd_val;
      if (w_resp && !r_rnw && w_is_io) r_io <= r_wdata;
    end
  end

  // Store is deliberately left out of reset; reset forces IDLE so an aborted write never lands.
  always_ff @(posedge mainClock) begin
    if (w_resp && !r_rnw && w_is_mem) r_mem[w_idx] <= r_wdata;
  end

  assign read_data = (w_resp && r_rnw) ? w_rd_val : r_rdata;
  assign ready     = w_resp;
  assign err       = w_resp && !w_is_io && !w_is_mem;
  assign busy      = (r_state != IDLE);
  assign io_out    = r_io;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench: stimulus queues expected responses, monitors pop them on each ready pulse.
module tb_data_bus_responder;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, rnw, cs0, rnw0;
  logic [11:0] addr, addr0;
  logic [23:0] wdata, wdata0;
  logic [23:0] rd, io, rd0, io0;
  logic        rdy, err, busy, rdy0, err0, busy0;

  typedef struct {
    logic [23:0] data;
    logic        err;
    logic        is_rd;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq0[$];
  exp_t m_e, m_e0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  data_bus_responder #(.WAIT_STATES(WS)) dut (
    .mainClock(clk), .reset(rst), .cs(cs), .read_not_write(rnw), .address(addr),
    .write_data(wdata), .read_data(rd), .ready(rdy), .err(err), .busy(busy), .io_out(io));

  data_bus_responder #(.WAIT_STATES(0)) dut0 (
    .mainClock(clk), .reset(rst), .cs(cs0), .read_not_write(rnw0), .address(addr0),
    .write_data(wdata0), .read_data(rd0), .ready(rdy0), .err(err0), .busy(busy0), .io_out(io0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rdy) begin
      if (sbq.size() == 0) flag("unexpected_ready");
      else begin
        m_e = sbq.pop_front();
        chk("resp_err", 32'(err), 32'(m_e.err));
        chk("resp_latency", cyc, m_e.cyc);
        if (m_e.is_rd) chk("resp_data", 32'(rd), 32'(m_e.data));
      end
    end else if (err) flag("err_without_ready");
  end

  always @(negedge clk) begin
    if (rdy0) begin
      if (sbq0.size() == 0) flag("ws0_unexpected_ready");
      else begin
        m_e0 = sbq0.pop_front();
        chk("ws0_resp_err", 32'(err0), 32'(m_e0.err));
        chk("ws0_resp_latency", cyc, m_e0.cyc);
        if (m_e0.is_rd) chk("ws0_resp_data", 32'(rd0), 32'(m_e0.data));
      end
    end else if (err0) flag("ws0_err_without_ready");
  end

  task automatic do_txn(input logic rnw_i, input logic [11:0] a, input logic [23:0] d,
                        input logic [23:0] exp_d, input logic exp_err, input logic glitch);
    exp_t t;
    int   k;
    @(negedge clk);
    rnw = rnw_i; addr = a; wdata = d; cs = 1'b1;
    t.data = exp_d; t.err = exp_err; t.is_rd = rnw_i; t.cyc = cyc + 1 + WS;
    sbq.push_back(t);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    while (!rdy && k < 20) begin
      if (glitch) begin
        addr  = 12'h003;
        wdata = 24'h777777;
      end
      @(negedge clk);
      k++;
    end
    if (!rdy) flag("ready_timeout");
    cs = 1'b0;
  endtask

  task automatic burst0(input logic rnw_i, input logic [11:0] a0, input logic [11:0] a1,
                        input logic [11:0] a2, input logic [23:0] d0, input logic [23:0] d1,
                        input logic [23:0] d2);
    logic [11:0] av [3];
    logic [23:0] dv [3];
    exp_t        t;
    int          idx;
    int          c;
    av[0] = a0; av[1] = a1; av[2] = a2;
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    @(negedge clk);
    rnw0 = rnw_i; addr0 = av[0]; wdata0 = dv[0]; cs0 = 1'b1;
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      t.data = dv[i]; t.err = 1'b0; t.is_rd = rnw_i; t.cyc = c + 1 + 2 * i;
      sbq0.push_back(t);
    end
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("ws0_ready_pattern", 32'(rdy0), 32'((k % 2) == 0));
      chk("ws0_busy_pattern", 32'(busy0), 32'((k % 2) == 0));
      if (rdy0 && idx < 2) begin
        idx++;
        addr0 = av[idx]; wdata0 = dv[idx];
      end
      if (k == 4) cs0 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rnw = 1'b0; addr = '0; wdata = '0;
    cs0 = 1'b0; rnw0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_data", 32'(rd), 32'd0);
    chk("rst_io_out", 32'(io), 32'd0);
    rst = 1'b0;

    do_txn(1'b0, 12'h010, 24'hABCDEF, 24'h0, 1'b0, 1'b0);
    do_txn(1'b1, 12'h010, 24'h0, 24'hABCDEF, 1'b0, 1'b0);
    do_txn(1'b0, 12'h011, 24'h000111, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rd_hold_after_write", 32'(rd), 32'hABCDEF);

    do_txn(1'b0, 12'hFFF, 24'h000123, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("io_out_after_write", 32'(io), 32'h000123);
    do_txn(1'b1, 12'hFFF, 24'h0, 24'h000123, 1'b0, 1'b0);

    do_txn(1'b0, 12'h000, 24'h0A0A0A, 24'h0, 1'b0, 1'b0);
    do_txn(1'b1, 12'h100, 24'h0, 24'h000000, 1'b1, 1'b0);
    do_txn(1'b0, 12'h100, 24'hFFFFFF, 24'h0, 1'b1, 1'b0);
    do_txn(1'b1, 12'h000, 24'h0, 24'h0A0A0A, 1'b0, 1'b0);
    do_txn(1'b1, 12'h011, 24'h0, 24'h000111, 1'b0, 1'b0);

    do_txn(1'b0, 12'h003, 24'h333333, 24'h0, 1'b0, 1'b0);
    do_txn(1'b0, 12'h040, 24'h444444, 24'h0, 1'b0, 1'b1);
    do_txn(1'b1, 12'h040, 24'h0, 24'h444444, 1'b0, 1'b0);
    do_txn(1'b1, 12'h003, 24'h0, 24'h333333, 1'b0, 1'b0);

    // Abort a write while it is still waiting.
    do_txn(1'b0, 12'h020, 24'h111111, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    rnw = 1'b0; addr = 12'h020; wdata = 24'h555555; cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(rdy), 32'd0);
    chk("async_rst_io_out", 32'(io), 32'd0);
    chk("async_rst_read_data", 32'(rd), 32'd0);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_txn(1'b1, 12'h020, 24'h0, 24'h111111, 1'b0, 1'b0);
    @(negedge clk);
    chk("io_out_after_abort", 32'(io), 32'd0);

    burst0(1'b0, 12'h005, 12'h006, 12'h007, 24'h050505, 24'h060606, 24'h070707);
    burst0(1'b1, 12'h007, 12'h005, 12'h006, 24'h070707, 24'h050505, 24'h060606);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("ws0_sb_drained", 32'(sbq0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
